// File: rtl/alu_pkg.sv
// Shared types for the two-requester ALU sharing controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    // Opcode encoding understood by Decode_And_Execute
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_ROL = 3'd4,
        OP_ASR = 3'd5,
        OP_EQ  = 3'd6,
        OP_GT  = 3'd7
    } alu_op_e;

    // Controller FSM states; encoding 2'd3 is unused and recovers to IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } alu_state_e;

    // One captured operation plus the requester that issued it
    typedef struct packed {
        logic [2:0] sel;
        logic [3:0] rs;
        logic [3:0] rt;
        logic       id;
    } alu_req_t;

    // Requester index of a one-hot two-way grant
    function automatic logic gnt_to_id(input logic [1:0] gnt);
        return gnt[1];
    endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/response bundle between two requesters, a consumer and the shared ALU controller.
// Latency: n/a (wiring only).
// Backpressure: reqX_ready gates each request, rsp_ready gates the response.
interface alu_share_ctrl_if;

    logic       req0_valid;
    logic       req0_ready;
    logic [2:0] req0_sel;
    logic [3:0] req0_rs;
    logic [3:0] req0_rt;

    logic       req1_valid;
    logic       req1_ready;
    logic [2:0] req1_sel;
    logic [3:0] req1_rs;
    logic [3:0] req1_rt;

    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [3:0] rsp_rd;

    // Requester/consumer side
    modport master (
        output req0_valid, req0_sel, req0_rs, req0_rt,
        output req1_valid, req1_sel, req1_rs, req1_rt,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_rd
    );

    // Controller side
    modport slave (
        input  req0_valid, req0_sel, req0_rs, req0_rt,
        input  req1_valid, req1_sel, req1_rs, req1_rt,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_rd
    );

endinterface

// File: rtl/Decode_And_Execute.sv
// Combinational 4-bit ALU: decodes a 3-bit opcode and produces a 4-bit result.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module Decode_And_Execute (
    input  logic [2:0] sel,
    input  logic [3:0] rs,
    input  logic [3:0] rt,
    output logic [3:0] rd
);

    // Opcode decode; arithmetic wraps modulo 16, compares are unsigned
    always_comb begin
        rd = 4'd0;
        case (sel)
            3'b000:  rd = rs + rt;
            3'b001:  rd = rs - rt;
            3'b010:  rd = rs & rt;
            3'b011:  rd = rs | rt;
            3'b100:  rd = {rs[2:0], rs[3]};
            3'b101:  rd = {rt[3], rt[3:1]};
            3'b110:  rd = {3'b111, rs == rt};
            3'b111:  rd = {3'b101, rs > rt};
            default: rd = 4'd0;
        endcase
    end

endmodule

// File: rtl/alu_rr_arb2.sv
// Two-way arbiter: round-robin on ties (FAIR_RR=1) or fixed priority to requester 0.
// Latency: 0 cycles (grant is combinational from valid/en/last_gnt).
// Backpressure: en low forces no grant; a single valid requester is granted directly.
module alu_rr_arb2 #(
    parameter bit FAIR_RR = 1'b1
) (
    input  logic [1:0] valid,
    input  logic       en,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    // One-hot grant; on a tie the requester not served last wins when fair
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (valid)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = FAIR_RR ? (last_gnt ? 2'b01 : 2'b10) : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters; result returned with owner ID.
// Latency: handshake cycle, one EXEC cycle, then rsp_valid; one op per 3 cycles at best.
// Backpressure: no request is accepted until the response leaves on rsp_ready.
// Optional grant counters: define ALU_SHARE_STATS_EN to add gnt_cnt0/gnt_cnt1.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter bit FAIR_RR = 1'b1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_share_ctrl_if.slave  bus
`ifdef ALU_SHARE_STATS_EN
    ,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    alu_state_e state_q;
    alu_state_e state_d;
    logic       last_gnt;
    logic [1:0] valid;
    logic [1:0] gnt;
    logic       arb_en;
    logic       hs;
    alu_req_t   op_in;
    alu_req_t   cap;
    logic [3:0] alu_rd;
    logic [3:0] rsp_rd_q;
    logic       rsp_id_q;

    assign valid  = {bus.req1_valid, bus.req0_valid};
    // Reset gates the arbiter so no ready escapes while rst_n is low
    assign arb_en = rst_n && (state_q == ST_IDLE);
    assign hs     = |gnt;

    alu_rr_arb2 #(
        .FAIR_RR (FAIR_RR)
    ) u_arb (
        .valid    (valid),
        .en       (arb_en),
        .last_gnt (last_gnt),
        .gnt      (gnt)
    );

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];

    // Select the winning requester's operands for capture
    always_comb begin
        op_in.sel = bus.req0_sel;
        op_in.rs  = bus.req0_rs;
        op_in.rt  = bus.req0_rt;
        op_in.id  = gnt_to_id(gnt);
        if (gnt[1]) begin
            op_in.sel = bus.req1_sel;
            op_in.rs  = bus.req1_rs;
            op_in.rt  = bus.req1_rt;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: accept in IDLE, one evaluate cycle, hold response until taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (hs) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture operands and remember the winner on each request handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap      <= '0;
            last_gnt <= 1'b1;
        end else if (hs) begin
            cap      <= op_in;
            last_gnt <= op_in.id;
        end
    end

    Decode_And_Execute u_alu (
        .sel (cap.sel),
        .rs  (cap.rs),
        .rt  (cap.rt),
        .rd  (alu_rd)
    );

    // Register the ALU result and owner in EXEC; held untouched through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rd_q <= 4'd0;
            rsp_id_q <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            rsp_rd_q <= alu_rd;
            rsp_id_q <= cap.id;
        end
    end

    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rd    = rsp_rd_q;
    assign bus.rsp_id    = rsp_id_q;

`ifdef ALU_SHARE_STATS_EN
    // Saturating per-requester grant counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (gnt[0] && (gnt_cnt0 != {CNT_W{1'b1}})) gnt_cnt0 <= gnt_cnt0 + 1'b1;
            if (gnt[1] && (gnt_cnt1 != {CNT_W{1'b1}})) gnt_cnt1 <= gnt_cnt1 + 1'b1;
        end
    end
`endif

endmodule
